// File: rtl/stream_demux2_pkg.sv
// Shared types and route constants for the 1:2 packet-aware stream demux.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_A,
    LOCK_B
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int NUM_OUT = 2;

endpackage

// File: rtl/stream_demux2_if.sv
// Bundle of the input stream, both output streams and the status outputs.
interface stream_demux2_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_sel;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_last;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_last;

  logic [CNT_W-1:0] a_pkt_cnt;
  logic [CNT_W-1:0] b_pkt_cnt;
  logic             sel_mismatch;

  modport slave (
    input  in_valid, in_data, in_last, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, a_last, b_valid, b_data, b_last,
           a_pkt_cnt, b_pkt_cnt, sel_mismatch
  );

  modport master (
    output in_valid, in_data, in_last, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, a_last, b_valid, b_data, b_last,
           a_pkt_cnt, b_pkt_cnt, sel_mismatch
  );
endinterface

// File: rtl/stream_demux2_slot.sv
// One-entry output register (valid/data/last) with its completed-packet counter.
module demux_out_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             lin,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             free,
  output logic [CNT_W-1:0] pkt_cnt
);

  // Slot can take a beat when empty or when its current beat leaves this cycle.
  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      data    <= '0;
      last    <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= din;
        last  <= lin;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (valid && ready && last)
        pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux2.sv
// 1:2 valid/ready demux: route chosen on a packet's first beat and held to its last.
module stream_demux2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  stream_demux2_if.slave  bus
);

  state_t state, state_nxt;
  logic   target;
  logic   acc;
  logic   mismatch_q;

  logic [NUM_OUT-1:0]            load;
  logic [NUM_OUT-1:0]            rdy;
  logic [NUM_OUT-1:0]            vld;
  logic [NUM_OUT-1:0]            lst;
  logic [NUM_OUT-1:0]            free;
  logic [NUM_OUT-1:0][WIDTH-1:0] dat;
  logic [NUM_OUT-1:0][CNT_W-1:0] cnt;

  always_comb begin
    target = bus.in_sel;
    unique case (state)
      LOCK_A:  target = SEL_A;
      LOCK_B:  target = SEL_B;
      default: target = bus.in_sel;
    endcase
  end

  // Only the target slot gates the input; the other output never stalls it.
  assign bus.in_ready = rst_n && free[target];
  assign acc          = bus.in_valid && bus.in_ready;

  assign rdy[SEL_A] = bus.a_ready;
  assign rdy[SEL_B] = bus.b_ready;

  genvar i;
  generate
    for (i = 0; i < NUM_OUT; i++) begin : g_slot
      assign load[i] = acc && (target == i[0]);

      demux_out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load[i]),
        .din     (bus.in_data),
        .lin     (bus.in_last),
        .ready   (rdy[i]),
        .valid   (vld[i]),
        .data    (dat[i]),
        .last    (lst[i]),
        .free    (free[i]),
        .pkt_cnt (cnt[i])
      );
    end
  endgenerate

  assign bus.a_valid   = vld[SEL_A];
  assign bus.a_data    = dat[SEL_A];
  assign bus.a_last    = lst[SEL_A];
  assign bus.a_pkt_cnt = cnt[SEL_A];
  assign bus.b_valid   = vld[SEL_B];
  assign bus.b_data    = dat[SEL_B];
  assign bus.b_last    = lst[SEL_B];
  assign bus.b_pkt_cnt = cnt[SEL_B];

  always_comb begin
    state_nxt = state;
    if (acc) begin
      unique case (state)
        IDLE:    if (!bus.in_last) state_nxt = (bus.in_sel == SEL_B) ? LOCK_B : LOCK_A;
        LOCK_A,
        LOCK_B:  if (bus.in_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mismatch_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Mid-packet select changes are flagged but ignored for routing.
      if (acc && (state != IDLE) && (bus.in_sel != target))
        mismatch_q <= 1'b1;
    end
  end

  assign bus.sel_mismatch = mismatch_q;

endmodule

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2: routing, locking, backpressure, wrap, reset.
module tb_stream_demux2;
  import stream_demux_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  stream_demux2_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic l);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.in_last  = l;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    // reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    chk("rst_a_valid", 32'(bus.a_valid), 32'h0);
    chk("rst_b_valid", 32'(bus.b_valid), 32'h0);
    chk("rst_a_data", 32'(bus.a_data), 32'h0);
    chk("rst_cnt", 32'({bus.a_pkt_cnt, bus.b_pkt_cnt}), 32'h0);
    chk("rst_mism", 32'(bus.sel_mismatch), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;

    // single-beat packet to A
    bus.a_ready = 1'b1;
    drive(1'b1, 1'b0, 8'hA5, 1'b1);
    chk("t1_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_a_valid", 32'(bus.a_valid), 32'h1);
    chk("t1_a_data", 32'(bus.a_data), 32'hA5);
    chk("t1_a_last", 32'(bus.a_last), 32'h1);
    chk("t1_b_valid", 32'(bus.b_valid), 32'h0);
    chk("t1_state", 32'(dut.state), 32'(IDLE));
    tick();
    chk("t1_a_cnt", 32'(bus.a_pkt_cnt), 32'h1);
    chk("t1_a_drain", 32'(bus.a_valid), 32'h0);

    // 3-beat packet locked to B while in_sel toggles mid-packet
    bus.b_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    tick();
    chk("t2_b1_data", 32'(bus.b_data), 32'h11);
    chk("t2_b1_valid", 32'(bus.b_valid), 32'h1);
    chk("t2_state", 32'(dut.state), 32'(LOCK_B));
    chk("t2_mism0", 32'(bus.sel_mismatch), 32'h0);
    drive(1'b1, 1'b0, 8'h22, 1'b0);
    chk("t2_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("t2_b2_data", 32'(bus.b_data), 32'h22);
    chk("t2_a_valid2", 32'(bus.a_valid), 32'h0);
    chk("t2_mism1", 32'(bus.sel_mismatch), 32'h1);
    drive(1'b1, 1'b0, 8'h33, 1'b1);
    tick();
    chk("t2_b3_data", 32'(bus.b_data), 32'h33);
    chk("t2_b3_last", 32'(bus.b_last), 32'h1);
    chk("t2_a_valid3", 32'(bus.a_valid), 32'h0);
    chk("t2_idle", 32'(dut.state), 32'(IDLE));
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t2_b_cnt", 32'(bus.b_pkt_cnt), 32'h1);
    chk("t2_a_cnt", 32'(bus.a_pkt_cnt), 32'h1);

    // B backpressure does not block A
    bus.b_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h44, 1'b1);
    tick();
    chk("t3_b_full", 32'(bus.b_valid), 32'h1);
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    chk("t3_b_blocked", 32'(bus.in_ready), 32'h0);
    drive(1'b1, 1'b0, 8'h66, 1'b1);
    chk("t3_a_open", 32'(bus.in_ready), 32'h1);
    tick();
    chk("t3_a_data", 32'(bus.a_data), 32'h66);
    chk("t3_a_valid", 32'(bus.a_valid), 32'h1);
    chk("t3_b_hold", 32'(bus.b_data), 32'h44);
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    chk("t3_b_blocked2", 32'(bus.in_ready), 32'h0);
    tick();
    chk("t3_b_stable", 32'({bus.b_valid, bus.b_last, bus.b_data}), 32'h344);
    chk("t3_a_cnt", 32'(bus.a_pkt_cnt), 32'h2);
    bus.b_ready = 1'b1;
    #1;
    chk("t3_b_release", 32'(bus.in_ready), 32'h1);
    tick();
    chk("t3_b_refill", 32'({bus.b_valid, bus.b_data}), 32'h155);
    chk("t3_b_cnt2", 32'(bus.b_pkt_cnt), 32'h2);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t3_b_cnt3", 32'(bus.b_pkt_cnt), 32'h3);
    chk("t3_b_empty", 32'(bus.b_valid), 32'h0);

    // back-to-back 4-beat packet to A, no bubbles
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 8'(k), (k == 4));
      chk($sformatf("t4_in_ready%0d", k), 32'(bus.in_ready), 32'h1);
      tick();
      chk($sformatf("t4_a_beat%0d", k), 32'({bus.a_valid, bus.a_data}), 32'h100 | 32'(k));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t4_a_cnt", 32'(bus.a_pkt_cnt), 32'h3);

    // counter wrap: 253 more single-beat packets take a_pkt_cnt 3 -> 255 -> 0
    drive(1'b1, 1'b0, 8'h5A, 1'b1);
    for (int k = 0; k < 253; k++) tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_cnt_ff", 32'(bus.a_pkt_cnt), 32'hFF);
    tick();
    chk("t5_cnt_wrap", 32'(bus.a_pkt_cnt), 32'h0);

    // reset while locked to B with a full B slot
    bus.b_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t6_pre_state", 32'(dut.state), 32'(LOCK_B));
    chk("t6_pre_bvalid", 32'(bus.b_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("t6_valids", 32'({bus.a_valid, bus.b_valid}), 32'h0);
    chk("t6_cnts", 32'({bus.a_pkt_cnt, bus.b_pkt_cnt}), 32'h0);
    chk("t6_mism", 32'(bus.sel_mismatch), 32'h0);
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    rst_n       = 1'b1;
    bus.b_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h88, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t6_post_a", 32'({bus.a_valid, bus.a_data}), 32'h188);
    chk("t6_post_b", 32'(bus.b_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- 1-to-2 demultiplexer for a valid/ready data stream. It is the inverse of the 2:1 select mux: one input stream is steered to output A or output B.
- Select follows mux polarity: in_sel=0 routes to A, in_sel=1 routes to B.
- Packet-aware: the select is sampled on the first beat of a packet and locked until the last beat.
- Each output has a one-entry registered slot, so the block sits between a producer and two independent consumers with full backpressure.

Parameters:
- WIDTH, 8, data width in bits.
- CNT_W, 8, width of each per-output packet counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  WIDTH  input payload.
- in_last  input  1  marks the final beat of a packet.
- in_sel  input  1  route select: 0 selects A, 1 selects B. Sampled only in IDLE.
- a_valid  output  1  output A beat valid.
- a_ready  input  1  output A consumer ready.
- a_data  output  WIDTH  output A payload.
- a_last  output  1  output A last marker.
- b_valid  output  1  output B beat valid.
- b_ready  input  1  output B consumer ready.
- b_data  output  WIDTH  output B payload.
- b_last  output  1  output B last marker.
- a_pkt_cnt  output  CNT_W  count of packets completed on A.
- b_pkt_cnt  output  CNT_W  count of packets completed on B.
- sel_mismatch  output  1  sticky flag: in_sel disagreed with the locked route on an accepted mid-packet beat.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State becomes IDLE.
  - a_valid, b_valid, a_last, b_last become 0; a_data, b_data become 0.
  - Both counters become 0; sel_mismatch becomes 0.
  - in_ready is forced 0 combinationally while rst_n=0.
  - Reset mid-packet discards the lock and any slot contents. No partial beat is emitted afterwards.
- Target select:
  - In IDLE, target = in_sel.
  - In LOCK_A, target = A; in LOCK_B, target = B.
- Slot free condition: free_x = !x_valid || x_ready.
- in_ready = rst_n && free_target. It depends combinationally on in_sel only in IDLE. The non-target output's state never affects in_ready.
- Accept: on in_valid && in_ready, the target slot loads data and last, and x_valid becomes 1 on the next cycle.
  - Latency is exactly 1 cycle from accept to x_valid.
  - A full slot drained in the same cycle it is refilled stays valid with the new beat. There is no bubble, so throughput is 1 beat/cycle per route.
- Slot drain: x_valid && x_ready with no refill clears x_valid next cycle. Data holds its last value.
- Output stability: while x_valid && !x_ready, x_data and x_last are stable.
- FSM states: IDLE, LOCK_A, LOCK_B.
  - IDLE, accepted beat with in_last=0: go to LOCK_A if in_sel=0, else LOCK_B.
  - IDLE, accepted beat with in_last=1: single-beat packet; stay in IDLE.
  - LOCK_x, accepted beat with in_last=1: go to IDLE.
  - LOCK_x, any other case: hold.
  - No accept: hold state.
- sel_mismatch: set when a beat is accepted in LOCK_x and in_sel differs from the locked route. It stays set until reset. Routing still follows the lock.
- Packet counters: x_pkt_cnt increments on x_valid && x_ready && x_last. It wraps modulo 2^CNT_W (all-ones goes to 0).
- Independence:
  - A stalled output blocks only packets targeting it.
  - A beat already held in the other slot keeps draining normally.
  - A and B may both handshake in the same cycle.

Decomposition:
- Package stream_demux_pkg holds:
  - the state enum (IDLE, LOCK_A, LOCK_B);
  - the constants SEL_A=1'b0 and SEL_B=1'b1.
- Sub-module demux_out_slot: one-entry valid/data/last register plus its packet counter, parameterised by WIDTH and CNT_W. It is instantiated twice.
- The top level holds the FSM, ready generation, and sel_mismatch.

Test Plan:
- Reset, then in_sel=0, one beat data=8'hA5 last=1, a_ready=1 -> a_valid=1 with a_data=A5 and a_last=1 exactly one cycle later; next cycle a_pkt_cnt=1; b_valid stays 0; state IDLE.
- 3-beat packet 11,22,33 with in_sel=1 on beat 1, in_sel toggled to 0 on beats 2-3 -> all beats appear on B in order; sel_mismatch=1; b_pkt_cnt=1; a_valid never 1.
- Hold b_ready=0 with B slot full -> a beat for B sees in_ready=0. A concurrent packet to A still passes. Raise b_ready -> the held B beat drains, then the new B beat is accepted.
- a_ready=1 continuously, 4-beat back-to-back stream -> in_ready stays 1, a_valid stays high 4 consecutive cycles with no bubble.
- Drive a_ready=1, 256 single-beat packets to A with CNT_W=8 -> a_pkt_cnt wraps from 8'hFF to 0.
- Assert rst_n=0 in LOCK_B with B slot full -> the next cycle shows all valids 0, counters 0, sel_mismatch 0, state IDLE; the first post-reset beat routes per in_sel.
